// File: rtl/team_06_wb_arbiter_if.sv
// Wishbone classic single-beat bus between the arbiter and the external slave.
interface team_06_wb_arbiter_if;
    logic [31:0] ADR_O;
    logic [31:0] DAT_O;
    logic [3:0]  SEL_O;
    logic        WE_O;
    logic        STB_O;
    logic        CYC_O;
    logic [31:0] DAT_I;
    logic        ACK_I;

    modport master (
        output ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O,
        input  DAT_I, ACK_I
    );

    modport slave (
        input  ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O,
        output DAT_I, ACK_I
    );
endinterface

// File: rtl/team_06_wb_arbiter.sv
// Round-robin arbiter sharing one Wishbone master port between N_REQ
// hold-until-done requesters, with ACK timeout abort.
//
// state  | meaning
// S_IDLE | no cycle in flight, arbitrating
// S_BUS  | Wishbone cycle in flight, waiting for ACK_I or timeout
// S_DONE | one-cycle completion pulse and bus turnaround
module team_06_wb_arbiter #(
    parameter int N_REQ   = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   en,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       we,
    input  logic [32*N_REQ-1:0]    adr,
    input  logic [32*N_REQ-1:0]    wdat,
    input  logic [4*N_REQ-1:0]     sel,
    output logic [31:0]            rdat,
    output logic [N_REQ-1:0]       done,
    output logic                   err,
    team_06_wb_arbiter_if.master   bus
);
    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

    state_t            state, state_n;
    logic [GW-1:0]     last_grant, last_grant_n;
    logic [GW-1:0]     grant, grant_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [31:0]       adr_n, dat_n, rdat_n;
    logic [3:0]        sel_n;
    logic              we_n, cyc_n, err_n;
    logic [N_REQ-1:0]  done_n;

    logic              found;
    logic [GW-1:0]     pick;
    logic [31:0]       pick_adr, pick_wdat;
    logic [3:0]        pick_sel;
    logic              pick_we;

    // Round-robin pick: first set req scanning upward from last_grant+1.
    always_comb begin
        found     = 1'b0;
        pick      = '0;
        pick_adr  = '0;
        pick_wdat = '0;
        pick_sel  = '0;
        pick_we   = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            int idx;
            idx = (int'(last_grant) + k) % N_REQ;
            if (!found && req[idx]) begin
                found     = 1'b1;
                pick      = GW'(idx);
                pick_adr  = adr[idx*32 +: 32];
                pick_wdat = wdat[idx*32 +: 32];
                pick_sel  = sel[idx*4 +: 4];
                pick_we   = we[idx];
            end
        end
    end

    // Next-state and next-output logic; everything defaults to hold.
    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        grant_n      = grant;
        cnt_n        = cnt;
        adr_n        = bus.ADR_O;
        dat_n        = bus.DAT_O;
        sel_n        = bus.SEL_O;
        we_n         = bus.WE_O;
        cyc_n        = bus.CYC_O;
        rdat_n       = rdat;
        done_n       = '0;
        err_n        = 1'b0;
        case (state)
            S_IDLE: begin
                if (en && found) begin
                    state_n = S_BUS;
                    grant_n = pick;
                    adr_n   = pick_adr;
                    dat_n   = pick_wdat;
                    sel_n   = pick_sel;
                    we_n    = pick_we;
                    cyc_n   = 1'b1;
                    cnt_n   = '0;
                end
            end
            S_BUS: begin
                if (bus.ACK_I) begin
                    state_n       = S_DONE;
                    cyc_n         = 1'b0;
                    done_n[grant] = 1'b1;
                    if (!bus.WE_O) begin
                        rdat_n = bus.DAT_I;
                    end
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    state_n       = S_DONE;
                    cyc_n         = 1'b0;
                    done_n[grant] = 1'b1;
                    err_n         = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_DONE: begin
                state_n      = S_IDLE;
                last_grant_n = grant;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state      <= S_IDLE;
            last_grant <= GW'(N_REQ - 1);
            grant      <= '0;
            cnt        <= '0;
            bus.ADR_O  <= '0;
            bus.DAT_O  <= '0;
            bus.SEL_O  <= '0;
            bus.WE_O   <= 1'b0;
            bus.STB_O  <= 1'b0;
            bus.CYC_O  <= 1'b0;
            rdat       <= '0;
            done       <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            last_grant <= last_grant_n;
            grant      <= grant_n;
            cnt        <= cnt_n;
            bus.ADR_O  <= adr_n;
            bus.DAT_O  <= dat_n;
            bus.SEL_O  <= sel_n;
            bus.WE_O   <= we_n;
            bus.STB_O  <= cyc_n;
            bus.CYC_O  <= cyc_n;
            rdat       <= rdat_n;
            done       <= done_n;
            err        <= err_n;
        end
    end
endmodule

// File: tb/tb_team_06_wb_arbiter.sv
// Directed testbench for team_06_wb_arbiter (N_REQ=3, TIMEOUT=8).
module tb_team_06_wb_arbiter;
    localparam int N = 3;

    logic            clk = 1'b0;
    logic            nrst = 1'b0;
    logic            en = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    we = '0;
    logic [32*N-1:0] adr = '0;
    logic [32*N-1:0] wdat = '0;
    logic [4*N-1:0]  sel = '0;
    logic [31:0]     rdat;
    logic [N-1:0]    done;
    logic            err;

    team_06_wb_arbiter_if bus();

    team_06_wb_arbiter #(.N_REQ(N), .TIMEOUT(8)) dut (
        .clk(clk), .nrst(nrst), .en(en), .req(req), .we(we),
        .adr(adr), .wdat(wdat), .sel(sel), .rdat(rdat),
        .done(done), .err(err), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc_no = 0;

    // Slave model: ACK after ack_wait STB cycles; ack_force drives ACK by hand.
    int          ack_wait = 0;
    int          stb_cycles = 0;
    logic [31:0] slave_data = '0;
    logic        slave_ack = 1'b0;
    logic        ack_force = 1'b0;

    assign bus.ACK_I = slave_ack | ack_force;
    assign bus.DAT_I = slave_data;

    always @(negedge clk) begin
        if (bus.STB_O) begin
            slave_ack = (stb_cycles == ack_wait);
            stb_cycles++;
        end else begin
            slave_ack = 1'b0;
            stb_cycles = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    // Step until a done pulse, counting CYC_O-high samples along the way.
    task automatic wait_done(input int budget, output int cyc_hi,
                             output logic [N-1:0] d, output logic e, output bit ok);
        cyc_hi = 0; d = '0; e = 1'b0; ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus.CYC_O) cyc_hi++;
            if (done !== '0) begin
                d = done; e = err; ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        tick(); tick();
        n_vec++; if (bus.CYC_O !== 1'b0) begin n_err++; $display("FAIL reset_cyc got %b want 0", bus.CYC_O); end
        n_vec++; if (bus.STB_O !== 1'b0) begin n_err++; $display("FAIL reset_stb got %b want 0", bus.STB_O); end
        n_vec++; if (bus.ADR_O !== 32'h0 || bus.DAT_O !== 32'h0 || bus.SEL_O !== 4'h0 || bus.WE_O !== 1'b0) begin
            n_err++; $display("FAIL reset_payload got %h %h %h %b want zeros", bus.ADR_O, bus.DAT_O, bus.SEL_O, bus.WE_O); end
        n_vec++; if (rdat !== 32'h0 || done !== '0 || err !== 1'b0) begin
            n_err++; $display("FAIL reset_status got rdat=%h done=%b err=%b want 0", rdat, done, err); end
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        int cyc_hi; logic [N-1:0] d; logic e; bit ok;
        adr[31:0] = 32'h3000_0010; we = '0;
        ack_wait = 2; slave_data = 32'hDEAD_BEEF;
        req = 3'b001;
        wait_done(20, cyc_hi, d, e, ok);
        req = '0;
        n_vec++; if (!ok) begin n_err++; $display("FAIL read_timeout got no done want done"); end
        n_vec++; if (cyc_hi !== 3) begin n_err++; $display("FAIL read_cyc_len got %0d want 3", cyc_hi); end
        n_vec++; if (d !== 3'b001 || e !== 1'b0) begin n_err++; $display("FAIL read_done got %b err=%b want 001 err=0", d, e); end
        n_vec++; if (rdat !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL read_rdat got %h want deadbeef", rdat); end
        tick();
        n_vec++; if (done !== '0) begin n_err++; $display("FAIL read_done_width got %b want 000", done); end
        tick();
    endtask

    task automatic test_single_write();
        int cyc_hi; int pay_bad; logic [N-1:0] d; logic e; bit ok;
        adr[63:32] = 32'h4000_0020; wdat[63:32] = 32'h1234_5678; sel[7:4] = 4'b0011;
        we = 3'b010; ack_wait = 3; slave_data = 32'h5555_AAAA;
        req = 3'b010;
        cyc_hi = 0; pay_bad = 0; ok = 1'b0; d = '0; e = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.CYC_O) begin
                cyc_hi++;
                if (bus.ADR_O !== 32'h4000_0020 || bus.DAT_O !== 32'h1234_5678 ||
                    bus.SEL_O !== 4'b0011 || bus.WE_O !== 1'b1 || bus.STB_O !== 1'b1) pay_bad++;
                adr[63:32] = 32'hFFFF_FFFF; wdat[63:32] = 32'h0; sel[7:4] = 4'hF; we = 3'b000;
            end
            if (done !== '0) begin d = done; e = err; ok = 1'b1; break; end
        end
        req = '0; we = '0;
        n_vec++; if (!ok) begin n_err++; $display("FAIL write_timeout got no done want done"); end
        n_vec++; if (cyc_hi !== 4) begin n_err++; $display("FAIL write_cyc_len got %0d want 4", cyc_hi); end
        n_vec++; if (pay_bad !== 0) begin n_err++; $display("FAIL write_payload got %0d bad cycles want 0", pay_bad); end
        n_vec++; if (d !== 3'b010 || e !== 1'b0) begin n_err++; $display("FAIL write_done got %b err=%b want 010 err=0", d, e); end
        n_vec++; if (rdat !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL write_rdat got %h want deadbeef", rdat); end
        tick(); tick();
    endtask

    task automatic test_round_robin();
        int cyc_hi; logic [N-1:0] d; logic e; bit ok;
        int t_last; logic [N-1:0] exp_d; logic [31:0] exp_rdat;
        t_last = 0;
        nrst = 1'b0; tick(); tick();
        we = '0; ack_wait = 0; slave_data = 32'hA000_0000;
        nrst = 1'b1; req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            exp_rdat = slave_data;
            wait_done(12, cyc_hi, d, e, ok);
            exp_d = 3'b001 << (k % 3);
            if (k == 5) req = '0;
            n_vec++; if (!ok || d !== exp_d || e !== 1'b0) begin
                n_err++; $display("FAIL rr_grant_%0d got %b err=%b want %b", k, d, e, exp_d); end
            n_vec++; if (cyc_hi !== 1) begin n_err++; $display("FAIL rr_cyc_len_%0d got %0d want 1", k, cyc_hi); end
            n_vec++; if (rdat !== exp_rdat) begin n_err++; $display("FAIL rr_rdat_%0d got %h want %h", k, rdat, exp_rdat); end
            if (k > 0) begin
                n_vec++; if (cyc_no - t_last !== 3) begin
                    n_err++; $display("FAIL rr_spacing_%0d got %0d want 3", k, cyc_no - t_last); end
            end
            t_last = cyc_no;
            slave_data = slave_data + 32'h11;
        end
        tick(); tick();
    endtask

    task automatic test_timeout();
        int cyc_hi; logic [N-1:0] d; logic e; bit ok;
        logic [31:0] prev;
        prev = rdat;
        ack_wait = 1000; slave_data = 32'hBAD0_BAD0;
        req = 3'b001;
        wait_done(30, cyc_hi, d, e, ok);
        req = '0;
        n_vec++; if (!ok || d !== 3'b001 || e !== 1'b1) begin n_err++; $display("FAIL to_done got %b err=%b want 001 err=1", d, e); end
        n_vec++; if (cyc_hi !== 8) begin n_err++; $display("FAIL to_cyc_len got %0d want 8", cyc_hi); end
        n_vec++; if (rdat !== prev) begin n_err++; $display("FAIL to_rdat got %h want %h", rdat, prev); end
        tick(); tick();
        // ACK on the final permitted cycle completes normally.
        ack_wait = 7; slave_data = 32'hCAFE_0001;
        req = 3'b001;
        wait_done(30, cyc_hi, d, e, ok);
        req = '0;
        n_vec++; if (!ok || d !== 3'b001 || e !== 1'b0) begin n_err++; $display("FAIL to_edge_done got %b err=%b want 001 err=0", d, e); end
        n_vec++; if (cyc_hi !== 8) begin n_err++; $display("FAIL to_edge_cyc_len got %0d want 8", cyc_hi); end
        n_vec++; if (rdat !== 32'hCAFE_0001) begin n_err++; $display("FAIL to_edge_rdat got %h want cafe0001", rdat); end
        tick(); tick();
        ack_wait = 1; slave_data = 32'hCAFE_0002;
        req = 3'b001;
        wait_done(30, cyc_hi, d, e, ok);
        req = '0;
        n_vec++; if (!ok || d !== 3'b001 || e !== 1'b0 || cyc_hi !== 2) begin
            n_err++; $display("FAIL to_after got %b err=%b len=%0d want 001 err=0 len=2", d, e, cyc_hi); end
        n_vec++; if (rdat !== 32'hCAFE_0002) begin n_err++; $display("FAIL to_after_rdat got %h want cafe0002", rdat); end
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        int cyc_hi; logic [N-1:0] d; logic e; bit ok; bit seen;
        adr[95:64] = 32'h5000_0030;
        ack_wait = 1000;
        req = 3'b100;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.CYC_O) begin seen = 1'b1; break; end
        end
        n_vec++; if (!seen) begin n_err++; $display("FAIL rm_start got no CYC want CYC"); end
        tick();
        n_vec++; if (bus.CYC_O !== 1'b1 || bus.ADR_O !== 32'h5000_0030) begin
            n_err++; $display("FAIL rm_bus got cyc=%b adr=%h want 1 50000030", bus.CYC_O, bus.ADR_O); end
        nrst = 1'b0;
        tick();
        n_vec++; if (bus.CYC_O !== 1'b0 || bus.STB_O !== 1'b0 || bus.ADR_O !== 32'h0 || done !== '0 || err !== 1'b0 || rdat !== 32'h0) begin
            n_err++; $display("FAIL rm_outputs got cyc=%b stb=%b adr=%h done=%b err=%b rdat=%h want zeros",
                              bus.CYC_O, bus.STB_O, bus.ADR_O, done, err, rdat); end
        tick();
        n_vec++; if (done !== '0) begin n_err++; $display("FAIL rm_no_done got %b want 000", done); end
        ack_wait = 0;
        req = 3'b111;
        nrst = 1'b1;
        wait_done(12, cyc_hi, d, e, ok);
        req = '0;
        n_vec++; if (!ok || d !== 3'b001) begin n_err++; $display("FAIL rm_first_grant got %b want 001", d); end
        tick(); tick();
    endtask

    task automatic test_enable();
        int cyc_hi; int held; logic [N-1:0] d; logic e; bit ok;
        en = 1'b0; req = 3'b100; held = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.CYC_O) held++;
        end
        n_vec++; if (held !== 0) begin n_err++; $display("FAIL en_hold got %0d CYC cycles want 0", held); end
        ack_wait = 2;
        en = 1'b1;
        tick();
        n_vec++; if (bus.CYC_O !== 1'b1) begin n_err++; $display("FAIL en_grant got %b want 1", bus.CYC_O); end
        en = 1'b0;
        wait_done(20, cyc_hi, d, e, ok);
        req = '0;
        n_vec++; if (!ok || d !== 3'b100 || e !== 1'b0) begin n_err++; $display("FAIL en_finish got %b err=%b want 100 err=0", d, e); end
        n_vec++; if (cyc_hi !== 2) begin n_err++; $display("FAIL en_cyc_len got %0d want 2", cyc_hi); end
        en = 1'b1;
        tick(); tick();
    endtask

    task automatic test_ack_idle();
        int bad;
        bad = 0;
        req = '0; ack_force = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done !== '0 || bus.CYC_O !== 1'b0 || err !== 1'b0) bad++;
        end
        ack_force = 1'b0;
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL ack_idle got %0d bad cycles want 0", bad); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_enable();
        test_ack_idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
